// File: rtl/fp_alu_seq.sv
// fp_alu_seq: multicycle FP/bitwise ALU with shift-add multiplier and serial normaliser.
// Define FP_ALU_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_alu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_operand,
    input  logic [W-1:0] b_operand,
    input  logic [3:0]   operation,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] alu_output,
    output logic         exception,
    output logic         overflow,
    output logic         underflow
);
    localparam int M  = MAN_W + 1;
    localparam int SW = M + 3;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(M + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EXEC  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] ADDS  = 3'd3;
    localparam logic [2:0] MUL   = 3'd4;
    localparam logic [2:0] NORM  = 3'd5;
    localparam logic [2:0] PACK  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_ADD = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic [2:0]            state;
    logic [W-1:0]          a_r, b_r, res;
    logic [3:0]            op_r;
    logic                  exc, ovf, unf;
    logic                  sign_r, sub_r, zero_r;
    logic signed [XW-1:0]  exp_r;
    logic [SW-1:0]         sig_x, sig_y;
    logic [2*M-1:0]        prod;
    logic [M-1:0]          mcand;
    logic [CW-1:0]         cnt;

    logic             sa, sb, inf_in;
    logic [EXP_W-1:0] ea, eb;
    logic [M-1:0]     ma, mb;

    // exponent 0 flushes the operand to zero, hidden bit included
    assign sa     = a_r[W-1];
    assign sb     = b_r[W-1] ^ (op_r == OP_SUB);
    assign ea     = a_r[W-2:MAN_W];
    assign eb     = b_r[W-2:MAN_W];
    assign ma     = (ea == '0) ? '0 : {1'b1, a_r[MAN_W-1:0]};
    assign mb     = (eb == '0) ? '0 : {1'b1, b_r[MAN_W-1:0]};
    assign inf_in = (&ea) | (&eb);

    logic             a_big;
    logic [EXP_W-1:0] ediff, sh;
    logic [SW-1:0]    big_s, sml_s, sml_al;

    always_comb begin
        a_big  = {ea, ma} >= {eb, mb};
        ediff  = a_big ? ea - eb : eb - ea;
        sh     = (ediff > EXP_W'(M + 2)) ? EXP_W'(M + 2) : ediff;
        big_s  = {a_big ? ma : mb, 3'b000};
        sml_s  = {a_big ? mb : ma, 3'b000};
        sml_al = sml_s >> sh;
        sml_al[0] = sml_al[0] | (|(sml_s & ~({SW{1'b1}} << sh)));
    end

    logic [SW:0]          sum;
    logic [M:0]           pacc;
    logic [SW-1:0]        mul_sig;
    logic [MAN_W-1:0]     man_t;
    logic signed [XW-1:0] exp_t;

    always_comb begin
        sum = sub_r ? {1'b0, sig_x} - {1'b0, sig_y}
                    : {1'b0, sig_x} + {1'b0, sig_y};
        pacc = {1'b0, prod[2*M-1:M]} + (prod[0] ? {1'b0, mcand} : '0);
        if (prod[2*M-1])
            mul_sig = {prod[2*M-1:M-2], |prod[M-3:0]};
        else
            mul_sig = {prod[2*M-2:M-3], |prod[M-4:0]};
        man_t = sig_x[SW-2:3];
        exp_t = exp_r;
`ifdef FP_ALU_ROUND_NEAREST_EN
        if (sig_x[2] && (sig_x[3] | sig_x[1] | sig_x[0])) begin
            man_t = man_t + MAN_W'(1);
            if (&sig_x[SW-2:3])
                exp_t = exp_r + XW'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            res    <= '0;
            exc    <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            sign_r <= 1'b0;
            sub_r  <= 1'b0;
            zero_r <= 1'b0;
            exp_r  <= '0;
            sig_x  <= '0;
            sig_y  <= '0;
            prod   <= '0;
            mcand  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a_operand;
                    b_r    <= b_operand;
                    op_r   <= operation;
                    res    <= '0;
                    exc    <= 1'b0;
                    ovf    <= 1'b0;
                    unf    <= 1'b0;
                    zero_r <= 1'b0;
                    state  <= EXEC;
                end
                EXEC: begin
                    state <= DONE;
                    case (op_r)
                        OP_OR:  res <= a_r | b_r;
                        OP_AND: res <= a_r & b_r;
                        OP_XOR: res <= a_r ^ b_r;
                        OP_SHL: res <= a_r << 1;
                        OP_SHR: res <= a_r >> 1;
                        OP_NOT: res <= ~a_r;
                        OP_ADD, OP_SUB: begin
                            if (inf_in) begin
                                exc <= 1'b1;
                                res <= {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            end else begin
                                state <= ALIGN;
                            end
                        end
                        OP_MUL: begin
                            sign_r <= sa ^ sb;
                            exp_r  <= XW'(ea) + XW'(eb) - BIAS;
                            if (inf_in) begin
                                exc <= 1'b1;
                                res <= {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            end else if (ma == '0 || mb == '0) begin
                                res <= {sa ^ sb, {(W-1){1'b0}}};
                            end else begin
                                prod  <= {{M{1'b0}}, mb};
                                mcand <= ma;
                                cnt   <= '0;
                                state <= MUL;
                            end
                        end
                        default: begin
                            exc <= 1'b1;
                            res <= '0;
                        end
                    endcase
                end
                ALIGN: begin
                    sig_x  <= big_s;
                    sig_y  <= sml_al;
                    sign_r <= a_big ? sa : sb;
                    exp_r  <= XW'(a_big ? ea : eb);
                    sub_r  <= sa ^ sb;
                    state  <= ADDS;
                end
                ADDS: begin
                    if (sum == '0) begin
                        zero_r <= 1'b1;
                        sign_r <= 1'b0;
                        state  <= PACK;
                    end else if (sum[SW]) begin
                        sig_x <= sum[SW:1] | SW'(sum[0]);
                        exp_r <= exp_r + XW'(1);
                        state <= NORM;
                    end else begin
                        sig_x <= sum[SW-1:0];
                        state <= NORM;
                    end
                end
                MUL: begin
                    prod <= {pacc, prod[M-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(M - 1))
                        state <= NORM;
                end
                NORM: begin
                    if (op_r == OP_MUL) begin
                        sig_x <= mul_sig;
                        if (prod[2*M-1])
                            exp_r <= exp_r + XW'(1);
                        state <= PACK;
                    end else if (sig_x[SW-1]) begin
                        state <= PACK;
                    end else begin
                        sig_x <= sig_x << 1;
                        exp_r <= exp_r - XW'(1);
                    end
                end
                PACK: begin
                    state <= DONE;
                    if (zero_r) begin
                        res <= {sign_r, {(W-1){1'b0}}};
                    end else if (exp_t >= EMAX) begin
                        ovf <= 1'b1;
                        res <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (exp_t[XW-1] || exp_t == '0) begin
                        unf <= 1'b1;
                        res <= {sign_r, {(W-1){1'b0}}};
                    end else begin
                        res <= {sign_r, exp_t[EXP_W-1:0], man_t};
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign alu_output = res;
    assign exception  = exc;
    assign overflow   = ovf;
    assign underflow  = unf;
endmodule

// File: tb/tb_fp_alu_seq.sv
// tb_fp_alu_seq: scoreboard bench for fp_alu_seq (single and half precision).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_fp_alu_seq;
    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_operand = '0;
    logic [31:0] b_operand = '0;
    logic [3:0]  operation = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_output;
    logic        exception, overflow, underflow;

    logic        h_in_valid = 1'b0;
    logic        h_in_ready;
    logic [15:0] h_a = '0;
    logic [15:0] h_b = '0;
    logic [3:0]  h_op = '0;
    logic        h_out_valid;
    logic        h_out_ready = 1'b1;
    logic [15:0] h_out;
    logic        h_exc, h_ovf, h_unf;

    exp_t sb[$];
    exp_t sb16[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ncyc = 0;
    bit   seen = 0;
    bit   seen16 = 0;

    always #5 clk = ~clk;

    fp_alu_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_operand), .b_operand(b_operand),
        .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_output(alu_output), .exception(exception),
        .overflow(overflow), .underflow(underflow)
    );

    fp_alu_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a_operand(h_a), .b_operand(h_b),
        .operation(h_op),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .alu_output(h_out), .exception(h_exc),
        .overflow(h_ovf), .underflow(h_unf)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got 0x%0h expected no output", alu_output);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1;
                        chk({e.nm, " latency"}, 32'(ncyc - e.acc), 32'(e.lat));
                    end
                    chk({e.nm, " result"}, alu_output, e.res);
                    chk({e.nm, " flags"}, 32'({exception, overflow, underflow}), 32'(e.flg));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
            if (h_out_valid) begin
                if (sb16.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out16: got 0x%0h expected no output", h_out);
                end else begin
                    e = sb16[0];
                    if (!seen16) begin
                        seen16 = 1;
                        chk({e.nm, " latency"}, 32'(ncyc - e.acc), 32'(e.lat));
                    end
                    chk({e.nm, " result"}, 32'(h_out), e.res);
                    chk({e.nm, " flags"}, 32'({h_exc, h_ovf, h_unf}), 32'(e.flg));
                    if (h_out_ready) begin
                        void'(sb16.pop_front());
                        seen16 = 0;
                    end
                end
            end
        end
    end

    task automatic send(input bit h, input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [2:0] f,
                        input int lat, input bit push);
        exp_t e;
        int   n;
        n = 0;
        if (h) begin
            h_in_valid = 1'b1; h_op = op; h_a = a[15:0]; h_b = b[15:0];
        end else begin
            in_valid = 1'b1; operation = op; a_operand = a; b_operand = b;
        end
        while (!(h ? h_in_ready : in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: in_ready got 0 expected 1 within 300 cycles", nm);
        end else begin
            @(posedge clk); #1;
            e.nm = nm; e.res = r; e.flg = f; e.lat = lat; e.acc = ncyc;
            if (push) begin
                if (h) sb16.push_back(e);
                else sb.push_back(e);
            end
        end
        if (h) h_in_valid = 1'b0;
        else in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sb16.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size() + sb16.size());
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst alu_output", alu_output, 32'd0);
        chk("rst flags", 32'({exception, overflow, underflow}), 32'd0);
        chk("rst16 in_ready", 32'(h_in_ready), 32'd1);

        send(1, "h_add_2", 4'd10, 32'h3C00, 32'h3C00, 32'h4000, 3'b000, 6, 1);
        send(0, "add_3p75", 4'd10, 32'h3FC00000, 32'h40100000, 32'h40700000, 3'b000, 6, 1);
        send(0, "mul_6", 4'd1, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 28, 1);
        send(0, "mul_ovf", 4'd1, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 28, 1);
        send(0, "mul_unf", 4'd1, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 28, 1);
        send(0, "mul_zero", 4'd1, 32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2, 1);
        send(0, "mul_inf", 4'd1, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b100, 2, 1);
        send(0, "add_inf", 4'd10, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b100, 2, 1);
        send(0, "sub_zero", 4'd3, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 5, 1);
        send(0, "sub_ulp", 4'd3, 32'h3F800001, 32'h3F800000, 32'h34000000, 3'b000, 29, 1);
        send(0, "add_mixed", 4'd10, 32'h40000000, 32'hBF800000, 32'h3F800000, 3'b000, 7, 1);
        send(0, "xor", 4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 3'b000, 2, 1);
        send(0, "or", 4'd4, 32'h12340000, 32'h00005678, 32'h12345678, 3'b000, 2, 1);
        send(0, "and", 4'd5, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 3'b000, 2, 1);
        send(0, "shl", 4'd7, 32'h80000001, 32'h0, 32'h00000002, 3'b000, 2, 1);
        send(0, "shr", 4'd8, 32'h80000001, 32'h0, 32'h40000000, 3'b000, 2, 1);
        send(0, "not", 4'd11, 32'h0000FFFF, 32'h0, 32'hFFFF0000, 3'b000, 2, 1);
        send(0, "illegal0", 4'd0, 32'h12345678, 32'h1, 32'h00000000, 3'b100, 2, 1);
        send(0, "illegal15", 4'd15, 32'h12345678, 32'h1, 32'h00000000, 3'b100, 2, 1);
        drain();

        out_ready = 1'b0;
        send(0, "xor_bp", 4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 3'b000, 2, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp out_valid seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        drain();

        send(0, "mul_abort", 4'd1, 32'h40000000, 32'h40400000, 32'h0, 3'b000, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort alu_output", alu_output, 32'd0);
        chk("abort flags", 32'({exception, overflow, underflow}), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        send(0, "add_after_rst", 4'd10, 32'h40000000, 32'hBF800000, 32'h3F800000, 3'b000, 7, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
